// File: rtl/msk_perm_l_seq.sv
// Masked Ascon linear diffusion layer (Sigma0..Sigma4), serialised over lanes.
// A job is captured into a source register and LPC lanes per cycle are
// diffused into a result register, which is then presented under valid/ready.
// All arithmetic is share-wise; share indices are never mixed.
//
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   flush       synchronous abort, highest priority, returns to IDLE
//   in_valid    in_state holds a job
//   in_ready    job can be accepted (IDLE only)
//   in_state    masked state, x0 in the MSBs, x4 in the LSBs;
//               inside a lane, bit i of share j sits at index i*D+j
//   out_valid   out_state holds a result
//   out_ready   consumer takes the result
//   out_state   masked result, same layout as in_state
module msk_perm_l_seq #(
  parameter int unsigned D   = 2,
  parameter int unsigned LPC = 1,
  parameter int unsigned W   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5*W*D-1:0] in_state,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5*W*D-1:0] out_state
);

  localparam int unsigned LW   = W * D;
  localparam int unsigned SW   = 5 * LW;
  localparam int unsigned LAST = 5 - LPC;

  // Elaboration guards on the parameter space
  if (!(LPC == 1 || LPC == 5)) begin : g_bad_lpc
    $error("msk_perm_l_seq: LPC must be 1 or 5");
  end
  if (W != 64) begin : g_bad_w
    $error("msk_perm_l_seq: W must be 64");
  end
  if (D < 2) begin : g_bad_d
    $error("msk_perm_l_seq: D must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [SW-1:0]   src_q, src_d;
  logic [SW-1:0]   result_q, result_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;

  // Rotate right: bit i moves to bit (i-r) mod W
  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int unsigned r);
    return (x >> r) | (x << (W - r));
  endfunction

  // Sigma of one lane, applied independently to each share
  function automatic logic [LW-1:0] sigma_lane(input logic [LW-1:0] x, input logic [2:0] idx);
    logic [W-1:0]  s;
    logic [W-1:0]  y;
    logic [LW-1:0] o;
    int unsigned   ra;
    int unsigned   rb;
    o = '0;
    case (idx)
      3'd0:    begin ra = 19; rb = 28; end
      3'd1:    begin ra = 61; rb = 39; end
      3'd2:    begin ra = 1;  rb = 6;  end
      3'd3:    begin ra = 10; rb = 17; end
      default: begin ra = 7;  rb = 41; end
    endcase
    for (int unsigned j = 0; j < D; j++) begin
      for (int unsigned i = 0; i < W; i++) s[i] = x[i*D+j];
      y = s ^ rotr(s, ra) ^ rotr(s, rb);
      for (int unsigned i = 0; i < W; i++) o[i*D+j] = y[i];
    end
    return o;
  endfunction

  // State register plus registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) state_d = S_BUSY;
        S_BUSY: if (cnt_q == 3'(LAST)) state_d = S_DONE;
        S_DONE: if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: handshake flags follow the state being entered
  always_comb begin
    out_valid_d = (state_d == S_DONE);
    in_ready_d  = (state_d == S_IDLE);
  end

  // Datapath next values: capture, per-lane diffusion, lane counter
  always_comb begin
    logic [2:0]  lane;
    int unsigned off;
    src_d    = src_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    lane     = '0;
    off      = 0;
    if (flush) begin
      result_d = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) src_d = in_state;
        S_BUSY: begin
          for (int unsigned p = 0; p < LPC; p++) begin
            lane = cnt_q + 3'(p);
            off  = (32'd4 - 32'(lane)) * LW;
            result_d[off +: LW] = sigma_lane(src_q[off +: LW], lane);
          end
          cnt_d = (cnt_q == 3'(LAST)) ? 3'd0 : cnt_q + 3'(LPC);
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      src_q    <= '0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      src_q    <= src_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = result_q;

endmodule

// File: tb/tb_msk_perm_l_seq.sv
// Directed bench for msk_perm_l_seq: d=2/LPC=1 handshake and corner cases,
// plus d=3 with LPC=1 and LPC=5 on random masked states.
module tb_msk_perm_l_seq;

  logic clk;
  logic rst_n;

  logic         a_fl, a_iv, a_ir, a_ov, a_or;
  logic [639:0] a_in, a_out;

  logic         bc_fl, bc_iv, bc_or;
  logic         b_ir, b_ov, c_ir, c_ov;
  logic [959:0] bc_in, b_out, c_out;

  int errors;
  int checks;

  msk_perm_l_seq #(.D(2), .LPC(1), .W(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_fl), .in_valid(a_iv), .in_ready(a_ir),
    .in_state(a_in), .out_valid(a_ov), .out_ready(a_or), .out_state(a_out));

  msk_perm_l_seq #(.D(3), .LPC(1), .W(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(bc_fl), .in_valid(bc_iv), .in_ready(b_ir),
    .in_state(bc_in), .out_valid(b_ov), .out_ready(bc_or), .out_state(b_out));

  msk_perm_l_seq #(.D(3), .LPC(5), .W(64)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(bc_fl), .in_valid(bc_iv), .in_ready(c_ir),
    .in_state(bc_in), .out_valid(c_ov), .out_ready(bc_or), .out_state(c_out));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference Sigma: y[i] = x[i] ^ x[i+a] ^ x[i+b] (indices mod 64)
  function automatic logic [63:0] sig_m(input logic [63:0] x, input int k);
    int ra[5];
    int rb[5];
    logic [63:0] y;
    ra = '{19, 61, 1, 10, 7};
    rb = '{28, 39, 6, 17, 41};
    for (int i = 0; i < 64; i++)
      y[i] = x[i] ^ x[(i + ra[k]) % 64] ^ x[(i + rb[k]) % 64];
    return y;
  endfunction

  function automatic logic [63:0] get_sh(input logic [959:0] st, input int dd, input int k, input int j);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = st[(4 - k) * 64 * dd + i * dd + j];
    return r;
  endfunction

  function automatic logic [959:0] model(input logic [959:0] st, input int dd);
    logic [959:0] r;
    logic [63:0]  y;
    r = '0;
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < dd; j++) begin
        y = sig_m(get_sh(st, dd, k, j), k);
        for (int i = 0; i < 64; i++) r[(4 - k) * 64 * dd + i * dd + j] = y[i];
      end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one job on dut_a and wait (bounded) for out_valid; lat=0 on timeout
  task automatic job_a(input logic [639:0] v, output int lat);
    a_in = v;
    a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (a_ov) begin
        lat = c;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_fl = 0; a_iv = 0; a_or = 0; a_in = '0;
    bc_fl = 0; bc_iv = 0; bc_or = 0; bc_in = '0;
    tick();
    tick();
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL reset_ov_a got=%b exp=0", a_ov); end
    checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL reset_ir_a got=%b exp=1", a_ir); end
    checks++; if (a_out !== 640'd0) begin errors++; $display("FAIL reset_out_a got=%h exp=0", a_out); end
    checks++; if ({b_ov, c_ov, b_ir, c_ir} !== 4'b0011) begin errors++; $display("FAIL reset_bc got=%b exp=0011", {b_ov, c_ov, b_ir, c_ir}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_latency();
    a_in = '0;
    a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      checks++; if (a_ir !== 1'b0) begin errors++; $display("FAIL zero_ir cycle=%0d got=%b exp=0", c, a_ir); end
      checks++; if (a_ov !== 1'(c == 6)) begin errors++; $display("FAIL zero_ov cycle=%0d got=%b exp=%b", c, a_ov, c == 6); end
      if (c < 6) tick();
    end
    checks++; if (a_out !== 640'd0) begin errors++; $display("FAIL zero_out got=%h exp=0", a_out); end
    a_or = 1'b1;
    tick();
    a_or = 1'b0;
    checks++; if (a_ir !== 1'b1 || a_ov !== 1'b0) begin errors++; $display("FAIL zero_release ir=%b ov=%b exp ir=1 ov=0", a_ir, a_ov); end
  endtask

  task automatic test_single_bit();
    logic [639:0] v;
    logic [639:0] e;
    int lat;
    v = '0; v[512] = 1'b1;
    e = '0; e[512] = 1'b1; e[584] = 1'b1; e[602] = 1'b1;
    job_a(v, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL bit_latency got=%0d exp=6", lat); end
    checks++; if (a_out !== e) begin errors++; $display("FAIL bit_out got=%h exp=%h", a_out, e); end
    a_or = 1'b1;
    tick();
    a_or = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [639:0] v;
    logic [959:0] m;
    logic [639:0] e;
    int lat;
    v = {5{64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210}};
    m = model(960'(v), 2);
    e = m[639:0];
    job_a(v, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL bp_latency got=%0d exp=6", lat); end
    checks++; if (a_out !== e) begin errors++; $display("FAIL bp_out got=%h exp=%h", a_out, e); end
    for (int i = 0; i < 10; i++) begin
      a_iv = 1'(i % 2);
      a_in = ~v;
      tick();
      checks++; if (a_ov !== 1'b1 || a_ir !== 1'b0) begin errors++; $display("FAIL bp_hold_flags cycle=%0d ov=%b ir=%b exp ov=1 ir=0", i, a_ov, a_ir); end
      checks++; if (a_out !== e) begin errors++; $display("FAIL bp_hold_out cycle=%0d got=%h exp=%h", i, a_out, e); end
    end
    a_iv = 1'b1;
    a_or = 1'b1;
    tick();
    a_or = 1'b0;
    checks++; if (a_ir !== 1'b1 || a_ov !== 1'b0) begin errors++; $display("FAIL bp_release ir=%b ov=%b exp ir=1 ov=0", a_ir, a_ov); end
    a_iv = 1'b0;
    tick();
    checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL bp_no_accept ir=%b exp=1", a_ir); end
  endtask

  task automatic test_async_reset();
    logic [639:0] v;
    logic [959:0] m;
    int lat;
    v = {5{64'hdead_beef_f00d_cafe, 64'h1357_9bdf_2468_ace0}};
    m = model(960'(v), 2);
    a_in = v;
    a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (a_ov !== 1'b0 || a_ir !== 1'b1) begin errors++; $display("FAIL arst_flags ov=%b ir=%b exp ov=0 ir=1", a_ov, a_ir); end
    checks++; if (a_out !== 640'd0) begin errors++; $display("FAIL arst_out got=%h exp=0", a_out); end
    #3;
    rst_n = 1'b1;
    tick();
    job_a(v, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL arst_latency got=%0d exp=6", lat); end
    checks++; if (a_out !== m[639:0]) begin errors++; $display("FAIL arst_out2 got=%h exp=%h", a_out, m[639:0]); end
    a_or = 1'b1;
    tick();
    a_or = 1'b0;
  endtask

  task automatic test_flush();
    logic [639:0] v3;
    logic [639:0] v4;
    logic [959:0] m;
    v3 = {10{64'ha5a5_5a5a_0f0f_f0f0}};
    v4 = {5{64'h8000_0000_0000_0001, 64'h0000_ffff_0000_ffff}};
    m = model(960'(v4), 2);
    a_in = v3;
    a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
    tick();
    a_fl = 1'b1;
    tick();
    a_fl = 1'b0;
    checks++; if (a_ir !== 1'b1 || a_ov !== 1'b0) begin errors++; $display("FAIL flush_flags ir=%b ov=%b exp ir=1 ov=0", a_ir, a_ov); end
    checks++; if (a_out !== 640'd0) begin errors++; $display("FAIL flush_out got=%h exp=0", a_out); end
    a_in = v4;
    a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      checks++; if (a_ov !== 1'(c == 6)) begin errors++; $display("FAIL flush_b2b_ov cycle=%0d got=%b exp=%b", c, a_ov, c == 6); end
      if (c < 6) tick();
    end
    checks++; if (a_out !== m[639:0]) begin errors++; $display("FAIL flush_b2b_out got=%h exp=%h", a_out, m[639:0]); end
    a_or = 1'b1;
    tick();
    a_or = 1'b0;
  endtask

  task automatic test_flush_idle();
    a_in = {10{64'h1111_2222_3333_4444}};
    a_fl = 1'b1;
    a_iv = 1'b1;
    tick();
    a_fl = 1'b0;
    a_iv = 1'b0;
    checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL flush_idle_ir got=%b exp=1", a_ir); end
    tick();
    checks++; if (a_ir !== 1'b1 || a_ov !== 1'b0) begin errors++; $display("FAIL flush_idle_later ir=%b ov=%b exp ir=1 ov=0", a_ir, a_ov); end
  endtask

  task automatic test_random_d3();
    logic [959:0] gb;
    logic [959:0] gc;
    logic [63:0]  xi, xb, xc;
    int lb, lc;
    bit okb, okc, oub, ouc;
    bc_or = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      for (int w = 0; w < 30; w++) bc_in[w*32 +: 32] = $urandom;
      bc_iv = 1'b1;
      tick();
      bc_iv = 1'b0;
      lb = 0; lc = 0; gb = '0; gc = '0;
      for (int c = 1; c <= 12; c++) begin
        if (b_ov && lb == 0) begin lb = c; gb = b_out; end
        if (c_ov && lc == 0) begin lc = c; gc = c_out; end
        if (lb != 0 && lc != 0) break;
        tick();
      end
      tick();
      okb = 1; okc = 1; oub = 1; ouc = 1;
      for (int k = 0; k < 5; k++) begin
        xi = '0; xb = '0; xc = '0;
        for (int j = 0; j < 3; j++) begin
          if (get_sh(gb, 3, k, j) !== sig_m(get_sh(bc_in, 3, k, j), k)) okb = 0;
          if (get_sh(gc, 3, k, j) !== sig_m(get_sh(bc_in, 3, k, j), k)) okc = 0;
          xi ^= get_sh(bc_in, 3, k, j);
          xb ^= get_sh(gb, 3, k, j);
          xc ^= get_sh(gc, 3, k, j);
        end
        if (xb !== sig_m(xi, k)) oub = 0;
        if (xc !== sig_m(xi, k)) ouc = 0;
      end
      checks++; if (lb !== 6) begin errors++; $display("FAIL rnd_lat_lpc1 job=%0d got=%0d exp=6", n, lb); end
      checks++; if (lc !== 2) begin errors++; $display("FAIL rnd_lat_lpc5 job=%0d got=%0d exp=2", n, lc); end
      checks++; if (!okb) begin errors++; $display("FAIL rnd_shares_lpc1 job=%0d got=%h exp=%h", n, gb, model(bc_in, 3)); end
      checks++; if (!okc) begin errors++; $display("FAIL rnd_shares_lpc5 job=%0d got=%h exp=%h", n, gc, model(bc_in, 3)); end
      checks++; if (!oub) begin errors++; $display("FAIL rnd_unmasked_lpc1 job=%0d got_ok=%0d exp_ok=1", n, oub); end
      checks++; if (!ouc) begin errors++; $display("FAIL rnd_unmasked_lpc5 job=%0d got_ok=%0d exp_ok=1", n, ouc); end
    end
    bc_or = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_zero_latency();
    test_single_bit();
    test_backpressure();
    test_async_reset();
    test_flush();
    test_flush_idle();
    test_random_d3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
